// File: rtl/bit_deser_if.sv
// Serial-bit input and parallel-word output bundle for bit_deser.
// The TB/driver side uses modport master; the deserializer uses modport slave.
interface bit_deser_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_vld;
  logic             sof;
  logic             word_rdy;
  logic [WIDTH-1:0] word_data;
  logic             word_vld;
  logic             par_err;
  logic             ovf;

  modport master (
    output bit_in, bit_vld, sof, word_rdy,
    input  word_data, word_vld, par_err, ovf
  );

  modport slave (
    input  bit_in, bit_vld, sof, word_rdy,
    output word_data, word_vld, par_err, ovf
  );
endinterface

// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer: MSB-first frames aligned by sof, one-entry output register.
// Define BIT_DESER_PARITY_EN to append an even-parity bit to each frame and report par_err.
//
// state | meaning
// IDLE  | waiting for sof; bits without sof are ignored
// SHIFT | assembling a frame; count 0 means the next bit starts a new frame
module bit_deser #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  bit_deser_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef BIT_DESER_PARITY_EN
  localparam logic [CW-1:0] CNT_PAR = CW'(WIDTH);
`endif

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             par_q, par_d;
  logic             ovf_q, ovf_d;

  logic             done;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_new;
  logic             par_new;

  assign shifted = {shreg_q[WIDTH-2:0], bus.bit_in};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    vld_d    = vld_q;
    par_d    = par_q;
    ovf_d    = ovf_q;
    done     = 1'b0;
    word_new = shifted;
    par_new  = 1'b0;

    if (bus.bit_vld) begin
      if (bus.sof) begin
        // sof always restarts, even on what would have been the completing bit
        shreg_d = {{(WIDTH-1){1'b0}}, bus.bit_in};
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
`ifdef BIT_DESER_PARITY_EN
        if (cnt_q == CNT_PAR) begin
          done     = 1'b1;
          word_new = shreg_q;
          par_new  = (^shreg_q) ^ bus.bit_in;
          cnt_d    = '0;
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
`else
        shreg_d = shifted;
        if (cnt_q == CNT_LAST) begin
          done  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
    end

    if (done) begin
      if (!vld_q || bus.word_rdy) begin
        data_d = word_new;
        par_d  = par_new;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (vld_q && bus.word_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      par_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.word_data = data_q;
  assign bus.word_vld  = vld_q;
  assign bus.par_err   = par_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser (WIDTH=8); honours BIT_DESER_PARITY_EN for the parity frames.
module tb_bit_deser;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  bit_deser_if #(.WIDTH(8)) bus ();

  bit_deser #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic step(input logic v, input logic b, input logic s);
    bus.bit_vld = v;
    bus.bit_in  = b;
    bus.sof     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic s, input logic gap, input logic pbit);
    for (int i = 7; i >= 0; i--) begin
      if (gap) step(1'b0, 1'b0, 1'b0);
      step(1'b1, w[i], s && (i == 7));
    end
`ifdef BIT_DESER_PARITY_EN
    if (gap) step(1'b0, 1'b0, 1'b0);
    step(1'b1, pbit, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] w;
    int         flen;
`ifdef BIT_DESER_PARITY_EN
    flen = 9;
`else
    flen = 8;
`endif
    reset        = 1'b1;
    bus.bit_in   = 1'b0;
    bus.bit_vld  = 1'b0;
    bus.sof      = 1'b0;
    bus.word_rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    check("rst_data", 32'(bus.word_data), 32'h00);
    check("rst_vld",  32'(bus.word_vld),  32'h0);
    check("rst_par",  32'(bus.par_err),   32'h0);
    check("rst_ovf",  32'(bus.ovf),       32'h0);

    // A5 with sof, valid exactly one cycle
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) step(1'b1, w[i], i == 7);
    check("a5_pre_vld", 32'(bus.word_vld), 32'h0);
    step(1'b1, w[0], 1'b0);
`ifdef BIT_DESER_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    check("a5_data", 32'(bus.word_data), 32'hA5);
    check("a5_vld",  32'(bus.word_vld),  32'h1);
    check("a5_par",  32'(bus.par_err),   32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("a5_vld_drop", 32'(bus.word_vld), 32'h0);

    // bits before any sof are ignored
    do_reset();
    w = 8'h3C;
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("nosof_vld", 32'(bus.word_vld), 32'h0);
    send_word(8'hC3, 1'b1, 1'b0, ^8'hC3);
    check("c3_data", 32'(bus.word_data), 32'hC3);
    check("c3_vld",  32'(bus.word_vld),  32'h1);
    step(1'b0, 1'b0, 1'b0);

    // back-to-back gapped frames, sof on first only
    do_reset();
    send_word(8'h12, 1'b1, 1'b1, ^8'h12);
    check("b2b_12_data", 32'(bus.word_data), 32'h12);
    check("b2b_12_vld",  32'(bus.word_vld),  32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_12_acc", 32'(bus.word_vld), 32'h0);
    send_word(8'h34, 1'b0, 1'b1, ^8'h34);
    check("b2b_34_data", 32'(bus.word_data), 32'h34);
    check("b2b_34_vld",  32'(bus.word_vld),  32'h1);
    step(1'b0, 1'b0, 1'b0);

    // overflow with consumer stalled
    bus.word_rdy = 1'b0;
    send_word(8'hF0, 1'b1, 1'b0, ^8'hF0);
    check("ovf_f0_data", 32'(bus.word_data), 32'hF0);
    check("ovf_f0_ovf",  32'(bus.ovf),       32'h0);
    send_word(8'h0F, 1'b0, 1'b0, ^8'h0F);
    check("ovf_hold_data", 32'(bus.word_data), 32'hF0);
    check("ovf_hold_vld",  32'(bus.word_vld),  32'h1);
    check("ovf_set",       32'(bus.ovf),       32'h1);
    bus.word_rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("ovf_acc_vld",  32'(bus.word_vld),  32'h0);
    check("ovf_sticky",   32'(bus.ovf),       32'h1);
    check("ovf_acc_data", 32'(bus.word_data), 32'hF0);

    // sof mid-frame restarts
    do_reset();
    check("rst2_ovf", 32'(bus.ovf), 32'h0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check("restart_pre_vld", 32'(bus.word_vld), 32'h0);
    send_word(8'h81, 1'b1, 1'b0, ^8'h81);
    check("restart_81_data", 32'(bus.word_data), 32'h81);
    check("restart_81_vld",  32'(bus.word_vld),  32'h1);
    step(1'b0, 1'b0, 1'b0);

    // sof on the would-be completing bit restarts instead of completing
    for (int i = 0; i < flen - 1; i++) step(1'b1, 1'b1, i == 0);
    step(1'b1, 1'b1, 1'b1);
    check("sofcomp_vld", 32'(bus.word_vld), 32'h0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
`ifdef BIT_DESER_PARITY_EN
    step(1'b1, 1'b1, 1'b0);
`endif
    check("sofcomp_data", 32'(bus.word_data), 32'h80);
    check("sofcomp_vld2", 32'(bus.word_vld),  32'h1);
    check("sofcomp_par",  32'(bus.par_err),   32'h0);
    step(1'b0, 1'b0, 1'b0);

    // reset mid-frame with a held word; reset beats a coincident sof
    bus.word_rdy = 1'b0;
    send_word(8'hAA, 1'b1, 1'b0, ^8'hAA);
    check("held_aa", 32'(bus.word_data), 32'hAA);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    check("midrst_data", 32'(bus.word_data), 32'h00);
    check("midrst_vld",  32'(bus.word_vld),  32'h0);
    check("midrst_par",  32'(bus.par_err),   32'h0);
    check("midrst_ovf",  32'(bus.ovf),       32'h0);
    bus.word_rdy = 1'b1;
    w = 8'hFF;
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0);
    check("midrst_idle_vld", 32'(bus.word_vld), 32'h0);
    send_word(8'h55, 1'b1, 1'b0, ^8'h55);
    check("midrst_55_data", 32'(bus.word_data), 32'h55);
    check("midrst_55_vld",  32'(bus.word_vld),  32'h1);
    step(1'b0, 1'b0, 1'b0);

`ifdef BIT_DESER_PARITY_EN
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    check("par_ok_data", 32'(bus.word_data), 32'hA5);
    check("par_ok_err",  32'(bus.par_err),   32'h0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b1);
    check("par_bad_data", 32'(bus.word_data), 32'hA5);
    check("par_bad_err",  32'(bus.par_err),   32'h1);
`else
    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    check("nopar_data", 32'(bus.word_data), 32'h5A);
    check("nopar_err",  32'(bus.par_err),   32'h0);
`endif
    step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
